window_3x3_line_buffer: RTL and testbench

- Streaming stage directly upstream of the 9-input median finder.
- Accepts a raster-order 8-bit pixel stream, one pixel per clock when valid.
- Keeps the two previous image lines in line buffers and emits a registered 3x3 neighbourhood on pixel0..pixel8, in the finder's row-major port order, for every fully populated window position.

---
 rtl/window_3x3_line_buffer_pkg.sv | 17 +
 rtl/window_3x3_line_buffer_line_buffer_ram.sv | 25 ++
 rtl/window_3x3_line_buffer.sv | 127 ++++++++++++
 tb/tb_window_3x3_line_buffer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/window_3x3_line_buffer_pkg.sv
// Shared defaults and the 3x3 window ordering used by the line buffer and the
// downstream 9-input median finder.
package window_3x3_line_buffer_pkg;

  localparam int unsigned PIX_W_DEF      = 8;
  localparam int unsigned IMG_WIDTH_DEF  = 640;
  localparam int unsigned IMG_HEIGHT_DEF = 480;

  localparam int unsigned WIN_DIM  = 3;
  localparam int unsigned WIN_TAPS = WIN_DIM * WIN_DIM;

  // Row-major window slot: row 0 is the oldest line, col 0 the oldest column.
  function automatic int unsigned win_idx(input int unsigned row, input int unsigned col);
    return row * WIN_DIM + col;
  endfunction

endpackage

// File: rtl/window_3x3_line_buffer_line_buffer_ram.sv
// Single-clock line RAM: combinational read of the addressed word and a
// registered write at the same address, so a read always returns the old data.
module line_buffer_ram #(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_3x3_line_buffer.sv
// Raster-stream 3x3 window generator: two line RAMs feed a 3x3 shift array and
// a registered window is emitted for every fully populated position.
module window_3x3_line_buffer
  import window_3x3_line_buffer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned PIX_W      = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic             out_last,
  output logic [PIX_W-1:0] pixel0,
  output logic [PIX_W-1:0] pixel1,
  output logic [PIX_W-1:0] pixel2,
  output logic [PIX_W-1:0] pixel3,
  output logic [PIX_W-1:0] pixel4,
  output logic [PIX_W-1:0] pixel5,
  output logic [PIX_W-1:0] pixel6,
  output logic [PIX_W-1:0] pixel7,
  output logic [PIX_W-1:0] pixel8
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]    col_q, col_d, col_cur;
  logic [RW-1:0]    row_q, row_d, row_cur;
  logic [PIX_W-1:0] tap_top, tap_mid;
  logic [PIX_W-1:0] win_q [WIN_TAPS];
  logic [PIX_W-1:0] win_d [WIN_TAPS];
  logic [PIX_W-1:0] pix_q [WIN_TAPS];
  logic [PIX_W-1:0] pix_d [WIN_TAPS];
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             fire;

  // A start-of-frame pixel is placed at (0,0) whatever the counters hold.
  assign col_cur = in_sof ? '0 : col_q;
  assign row_cur = in_sof ? '0 : row_q;

  line_buffer_ram #(.DEPTH(IMG_WIDTH), .DATA_W(PIX_W), .ADDR_W(CW)) u_lb0 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (col_cur),
    .wdata (in_pixel),
    .rdata (tap_mid)
  );

  line_buffer_ram #(.DEPTH(IMG_WIDTH), .DATA_W(PIX_W), .ADDR_W(CW)) u_lb1 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (col_cur),
    .wdata (tap_mid),
    .rdata (tap_top)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    pix_d       = pix_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    fire        = in_valid && (row_cur >= RW'(2)) && (col_cur >= CW'(2));
    if (in_valid) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
      for (int unsigned r = 0; r < WIN_DIM; r++) begin
        win_d[win_idx(r, 0)] = win_q[win_idx(r, 1)];
        win_d[win_idx(r, 1)] = win_q[win_idx(r, 2)];
      end
      win_d[win_idx(0, 2)] = tap_top;
      win_d[win_idx(1, 2)] = tap_mid;
      win_d[win_idx(2, 2)] = in_pixel;
      if (fire) begin
        out_valid_d = 1'b1;
        out_last_d  = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
        pix_d       = win_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int unsigned i = 0; i < WIN_TAPS; i++) begin
        win_q[i] <= '0;
        pix_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      win_q       <= win_d;
      pix_q       <= pix_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign pixel0    = pix_q[0];
  assign pixel1    = pix_q[1];
  assign pixel2    = pix_q[2];
  assign pixel3    = pix_q[3];
  assign pixel4    = pix_q[4];
  assign pixel5    = pix_q[5];
  assign pixel6    = pix_q[6];
  assign pixel7    = pix_q[7];
  assign pixel8    = pix_q[8];

endmodule

// File: tb/tb_window_3x3_line_buffer.sv
// Bench for window_3x3_line_buffer: a 4x4 and a 5x5 instance checked against a
// frame-image reference model with randomized input gaps and pixel values.
module tb_window_3x3_line_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       iv0 = 1'b0, isof0 = 1'b0, iv1 = 1'b0, isof1 = 1'b0;
  logic [7:0] ipx0 = '0, ipx1 = '0;
  logic       ov0, ol0, ov1, ol1;
  logic [7:0] pa [9];
  logic [7:0] pb [9];

  window_3x3_line_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_sof(isof0), .in_pixel(ipx0),
    .out_valid(ov0), .out_last(ol0),
    .pixel0(pa[0]), .pixel1(pa[1]), .pixel2(pa[2]), .pixel3(pa[3]), .pixel4(pa[4]),
    .pixel5(pa[5]), .pixel6(pa[6]), .pixel7(pa[7]), .pixel8(pa[8])
  );

  window_3x3_line_buffer #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .PIX_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_sof(isof1), .in_pixel(ipx1),
    .out_valid(ov1), .out_last(ol1),
    .pixel0(pb[0]), .pixel1(pb[1]), .pixel2(pb[2]), .pixel3(pb[3]), .pixel4(pb[4]),
    .pixel5(pb[5]), .pixel6(pb[6]), .pixel7(pb[7]), .pixel8(pb[8])
  );

  int unsigned passed = 0, total = 0;

  // Reference model: the frame image seen so far plus the raster position.
  int unsigned dim [2] = '{4, 5};
  int unsigned mr [2] = '{0, 0};
  int unsigned mc [2] = '{0, 0};
  logic [7:0]  img [2][8][8];
  logic        pv [2] = '{1'b0, 1'b0};
  logic        pl [2] = '{1'b0, 1'b0};
  logic [71:0] pw [2];
  logic [71:0] held [2] = '{72'h0, 72'h0};
  int unsigned vcnt [2] = '{0, 0};
  logic [71:0] obs4 [$];
  logic [71:0] obs5 [$];

  task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [71:0] act_win(input int d);
    logic [71:0] w = '0;
    for (int i = 0; i < 9; i++) w = {w[63:0], (d == 0) ? pa[i] : pb[i]};
    return w;
  endfunction

  function automatic logic [71:0] qget(input int d, input int i);
    if (d == 0) return (i < obs4.size()) ? obs4[i] : 72'hx;
    return (i < obs5.size()) ? obs5[i] : 72'hx;
  endfunction

  // Check the outputs produced by the previous edge, then drive the next cycle.
  task automatic step(input int d, input bit v, input bit sof, input logic [7:0] pix, input bit rst);
    logic [71:0] w;
    @(negedge clk);
    for (int dd = 0; dd < 2; dd++) begin
      w = act_win(dd);
      chk($sformatf("valid%0d", dd), {71'h0, (dd == 0) ? ov0 : ov1}, {71'h0, pv[dd]});
      if (pv[dd]) begin
        chk($sformatf("win%0d", dd), w, pw[dd]);
        chk($sformatf("last%0d", dd), {71'h0, (dd == 0) ? ol0 : ol1}, {71'h0, pl[dd]});
        held[dd] = pw[dd];
        vcnt[dd]++;
        if (dd == 0) obs4.push_back(w); else obs5.push_back(w);
      end else begin
        chk($sformatf("hold%0d", dd), w, held[dd]);
        chk($sformatf("idle_last%0d", dd), {71'h0, (dd == 0) ? ol0 : ol1}, 72'h0);
      end
      pv[dd] = 1'b0;
    end
    iv0 = 1'b0; isof0 = 1'b0; iv1 = 1'b0; isof1 = 1'b0;
    rst_n = !rst;
    if (rst) begin
      for (int dd = 0; dd < 2; dd++) begin
        mr[dd] = 0; mc[dd] = 0; held[dd] = '0;
      end
    end else if (v) begin
      if (d == 0) begin iv0 = 1'b1; isof0 = sof; ipx0 = pix; end
      else        begin iv1 = 1'b1; isof1 = sof; ipx1 = pix; end
      if (sof) begin mr[d] = 0; mc[d] = 0; end
      img[d][mr[d]][mc[d]] = pix;
      if (mr[d] >= 2 && mc[d] >= 2) begin
        pv[d] = 1'b1;
        pl[d] = (mr[d] == dim[d] - 1) && (mc[d] == dim[d] - 1);
        w = '0;
        for (int i = 0; i < 9; i++) w = {w[63:0], img[d][mr[d] - 2 + i / 3][mc[d] - 2 + i % 3]};
        pw[d] = w;
      end
      mc[d]++;
      if (mc[d] == dim[d]) begin
        mc[d] = 0;
        mr[d] = (mr[d] == dim[d] - 1) ? 0 : mr[d] + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic frame(input int d, input int base, input bit gaps, input bit sof,
                       input int npix, input bit rnd);
    int unsigned w = dim[d];
    for (int k = 0; k < npix; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      step(d, 1'b1, sof && (k == 0),
           rnd ? 8'($urandom_range(0, 255)) : 8'(base + int'(w) * (k / int'(w)) + k % int'(w)), 1'b0);
    end
  endtask

  int unsigned c0;

  initial begin
    @(posedge clk);
    step(0, 1'b0, 1'b0, 8'h0, 1'b1);
    step(0, 1'b0, 1'b0, 8'h0, 1'b0);

    // 4x4 continuous, then with random idle gaps
    for (int g = 0; g < 2; g++) begin
      obs4.delete(); c0 = vcnt[0];
      frame(0, 0, g[0], 1'b1, 16, 1'b0);
      idle(3);
      chk("count4", 72'(vcnt[0] - c0), 72'd4);
      chk("first4", qget(0, 0), 72'h000102040506_08090A);
      chk("final4", qget(0, 3), 72'h050607090A0B_0D0E0F);
    end

    // back-to-back frames, second offset by 100
    obs4.delete(); c0 = vcnt[0];
    frame(0, 0, 1'b0, 1'b1, 16, 1'b0);
    frame(0, 100, 1'b0, 1'b1, 16, 1'b0);
    idle(3);
    chk("count_b2b", 72'(vcnt[0] - c0), 72'd8);
    chk("first_f2", qget(0, 4), 72'h646566686_96A6C6D6E);

    // 5x5: frame aborted by in_sof at (1,2), then a complete frame
    obs5.delete(); c0 = vcnt[1];
    frame(1, 0, 1'b0, 1'b1, 7, 1'b0);
    frame(1, 0, 1'b0, 1'b1, 25, 1'b0);
    idle(3);
    chk("count_abort", 72'(vcnt[1] - c0), 72'd9);
    chk("first_abort", qget(1, 0), 72'h000102050607_0A0B0C);

    // reset after 7 pixels, then a full frame without in_sof
    frame(0, 0, 1'b0, 1'b1, 7, 1'b0);
    step(0, 1'b0, 1'b0, 8'h0, 1'b1);
    obs4.delete(); c0 = vcnt[0];
    frame(0, 0, 1'b1, 1'b0, 16, 1'b0);
    idle(3);
    chk("count_rst", 72'(vcnt[0] - c0), 72'd4);
    chk("first_rst", qget(0, 0), 72'h000102040506_08090A);

    // random pixels and gaps on both sizes
    for (int f = 0; f < 3; f++) begin
      frame(1, 0, 1'b1, f == 0, 25, 1'b1);
      frame(0, 0, 1'b1, f == 0, 16, 1'b1);
    end
    idle(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
